// File: rtl/resample_cfgseq.sv
// Configuration sequencer for the arbitrary-rate resampler: holds host shadow
// registers and replays them atomically onto cin/cwr after a commit.
module resample_cfgseq #(
  parameter logic [15:0] TMO = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hd,
  input  logic [2:0]  ha,
  input  logic        hwe,
  input  logic        go,
  input  logic        of,
  output logic [15:0] cin,
  output logic [3:0]  cwr,
  output logic        busy,
  output logic        done,
  output logic        herr,
  output logic        tmo
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_LSW, S_MSW, S_PH3, S_PH2, S_PH1, S_PH0, S_MODE, S_DONE
  } state_t;

  state_t      state;
  logic [11:0] lsw;
  logic [15:0] msw;
  logic [15:0] ph0, ph1, ph2, ph3;
  logic [3:0]  mode;
  logic        sync;
  logic [15:0] cnt;

  // NOTE: the shadows are reset like any control register because their
  // reset values (rate = 1.0) are what a commit straight after reset emits.
  always_ff @(posedge clk) begin
    if (rst) begin
      lsw  <= '0;
      msw  <= 16'h1000;
      ph0  <= '0;
      ph1  <= '0;
      ph2  <= '0;
      ph3  <= '0;
      mode <= '0;
      sync <= 1'b0;
    end else if (hwe && state == S_IDLE) begin
      case (ha)
        3'd0: lsw  <= hd[15:4];
        3'd1: msw  <= hd;
        3'd2: ph0  <= hd;
        3'd3: ph1  <= hd;
        3'd4: ph2  <= hd;
        3'd5: ph3  <= hd;
        3'd6: mode <= hd[3:0];
        3'd7: sync <= hd[0];
        default: ;
      endcase
    end
  end

  // Each write state registers its own word, so cin/cwr trail the state by
  // one cycle; LSW and MSW always leave on consecutive edges.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cin   <= '0;
      cwr   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      herr  <= 1'b0;
      tmo   <= 1'b0;
      cnt   <= TMO;
    end else begin
      cin  <= '0;
      cwr  <= '0;
      done <= 1'b0;
      if (state != S_IDLE && (hwe || go)) herr <= 1'b1;
      case (state)
        S_IDLE: if (go) begin
          state <= S_WAIT;
          busy  <= 1'b1;
          tmo   <= 1'b0;
          cnt   <= TMO;
        end
        S_WAIT: begin
          if (!sync || of) begin
            state <= S_LSW;
          end else if (cnt == 16'd0) begin
            state <= S_LSW;
            tmo   <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_LSW:  begin cwr <= 4'b0001; cin <= {lsw, 4'h0};       state <= S_MSW;  end
        S_MSW:  begin cwr <= 4'b0010; cin <= msw;               state <= S_PH3;  end
        S_PH3:  begin cwr <= 4'b0100; cin <= ph3;               state <= S_PH2;  end
        S_PH2:  begin cwr <= 4'b0100; cin <= ph2;               state <= S_PH1;  end
        S_PH1:  begin cwr <= 4'b0100; cin <= ph1;               state <= S_PH0;  end
        S_PH0:  begin cwr <= 4'b0100; cin <= ph0;               state <= S_MODE; end
        S_MODE: begin cwr <= 4'b1000; cin <= {12'h000, mode};   state <= S_DONE; end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resample_cfgseq.sv
// Bench for resample_cfgseq: two instances (long and short timeout) share the
// host inputs and are compared against a register-file reference model.
module tb_resample_cfgseq;

  localparam logic [15:0] TMO_A = 16'd64;
  localparam logic [15:0] TMO_B = 16'd8;

  logic        clk = 1'b0;
  logic        rst, hwe, go, of;
  logic [15:0] hd;
  logic [2:0]  ha;
  logic [15:0] cin  [2];
  logic [3:0]  cwr  [2];
  logic        busy [2];
  logic        done [2];
  logic        herr [2];
  logic        tmo  [2];

  resample_cfgseq #(.TMO(TMO_A)) dut_a (
    .clk(clk), .rst(rst), .hd(hd), .ha(ha), .hwe(hwe), .go(go), .of(of),
    .cin(cin[0]), .cwr(cwr[0]), .busy(busy[0]), .done(done[0]),
    .herr(herr[0]), .tmo(tmo[0])
  );

  resample_cfgseq #(.TMO(TMO_B)) dut_b (
    .clk(clk), .rst(rst), .hd(hd), .ha(ha), .hwe(hwe), .go(go), .of(of),
    .cin(cin[1]), .cwr(cwr[1]), .busy(busy[1]), .done(done[1]),
    .herr(herr[1]), .tmo(tmo[1])
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the eight host registers as written, plus sticky error.
  logic [15:0] m_reg [8];
  logic        m_herr;
  logic [15:0] obs_cin [7];
  logic [3:0]  obs_cwr [7];

  typedef struct {
    logic [2:0]  ha;
    logic [15:0] hd;
    int          slot;
    logic [3:0]  cwr;
    logic [15:0] cin;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_reg  = '{16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    m_herr = 1'b0;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    ha  = a;
    hd  = d;
    hwe = 1'b1;
    tick();
    hwe = 1'b0;
    m_reg[a] = d;
  endtask

  // Emission order: rate LSW, rate MSW, phase 3 down to 0, mode.
  function automatic logic [19:0] exp_word(input int i);
    case (i)
      0:       return {4'b0001, m_reg[0] & 16'hFFF0};
      1:       return {4'b0010, m_reg[1]};
      6:       return {4'b1000, 12'h000, m_reg[6][3:0]};
      default: return {4'b0100, m_reg[7 - i]};
    endcase
  endfunction

  // Issue go and follow both instances until the later one pulses done.
  // of_edge / inj_edge are counted in clock edges after the go edge (-1 = never).
  task automatic commit(input int of_edge, input int inj_edge);
    int          start [2];
    logic        exp_tmo [2];
    int          last;
    logic [15:0] tmo_v;
    logic [19:0] w;
    last = 0;
    for (int d = 0; d < 2; d++) begin
      int ex;
      tmo_v      = (d == 0) ? TMO_A : TMO_B;
      ex         = 1;
      exp_tmo[d] = 1'b0;
      if (m_reg[7][0]) begin
        if (of_edge >= 1 && of_edge <= int'(tmo_v) + 1) ex = of_edge;
        else begin
          ex         = int'(tmo_v) + 1;
          exp_tmo[d] = 1'b1;
        end
      end
      start[d] = ex + 1;
      if (start[d] + 7 > last) last = start[d] + 7;
    end
    go = 1'b1;
    of = (of_edge == 0);
    tick();
    go = 1'b0;
    of = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("busy_at_go[%0d]", d), 32'(busy[d]), 32'd1);
      check($sformatf("tmo_clear_at_go[%0d]", d), 32'(tmo[d]), 32'd0);
    end
    for (int e = 1; e <= last; e++) begin
      of = (e == of_edge);
      if (e == inj_edge) begin
        hwe    = 1'b1;
        ha     = 3'd1;
        hd     = 16'hFFFF;
        go     = 1'b1;
        m_herr = 1'b1;
      end
      tick();
      of  = 1'b0;
      hwe = 1'b0;
      go  = 1'b0;
      for (int d = 0; d < 2; d++) begin
        int k;
        k = e - start[d];
        w = (k >= 0 && k < 7) ? exp_word(k) : 20'h0;
        check($sformatf("cwr[%0d]@%0d", d, e), 32'(cwr[d]), 32'(w[19:16]));
        check($sformatf("cin[%0d]@%0d", d, e), 32'(cin[d]), 32'(w[15:0]));
        check($sformatf("done[%0d]@%0d", d, e), 32'(done[d]), 32'(k == 7));
        check($sformatf("busy[%0d]@%0d", d, e), 32'(busy[d]), 32'(k < 7));
        if (d == 0 && k >= 0 && k < 7) begin
          obs_cin[k] = cin[0];
          obs_cwr[k] = cwr[0];
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("tmo[%0d]", d), 32'(tmo[d]), 32'(exp_tmo[d]));
      check($sformatf("herr[%0d]", d), 32'(herr[d]), 32'(m_herr));
    end
  endtask

  vec_t vecs [7];

  initial begin
    rst = 1'b1; hwe = 1'b0; go = 1'b0; of = 1'b0; hd = '0; ha = '0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_cin[%0d]", d), 32'(cin[d]), 32'd0);
      check($sformatf("rst_cwr[%0d]", d), 32'(cwr[d]), 32'd0);
      check($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst_done[%0d]", d), 32'(done[d]), 32'd0);
      check($sformatf("rst_herr[%0d]", d), 32'(herr[d]), 32'd0);
      check($sformatf("rst_tmo[%0d]", d), 32'(tmo[d]), 32'd0);
    end

    // Reset defaults: rate 1.0, everything else zero.
    commit(-1, -1);
    check("default_msw", 32'(obs_cin[1]), 32'h1000);
    check("default_lsw", 32'(obs_cin[0]), 32'h0000);

    // Full load, table-driven: register written, slot it is emitted in, word.
    vecs[0] = '{3'd0, 16'hABC0, 0, 4'b0001, 16'hABC0};
    vecs[1] = '{3'd1, 16'h1234, 1, 4'b0010, 16'h1234};
    vecs[2] = '{3'd2, 16'h0011, 5, 4'b0100, 16'h0011};
    vecs[3] = '{3'd3, 16'h0022, 4, 4'b0100, 16'h0022};
    vecs[4] = '{3'd4, 16'h0033, 3, 4'b0100, 16'h0033};
    vecs[5] = '{3'd5, 16'h0044, 2, 4'b0100, 16'h0044};
    vecs[6] = '{3'd6, 16'h000D, 6, 4'b1000, 16'h000D};
    for (int i = 0; i < 7; i++) host_write(vecs[i].ha, vecs[i].hd);
    commit(-1, -1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("load_cwr_slot%0d", vecs[i].slot), 32'(obs_cwr[vecs[i].slot]), 32'(vecs[i].cwr));
      check($sformatf("load_cin_slot%0d", vecs[i].slot), 32'(obs_cin[vecs[i].slot]), 32'(vecs[i].cin));
    end

    // Sync alignment: of 37 edges after go (short-timeout instance times out).
    host_write(3'd7, 16'h0001);
    commit(37, -1);
    // Timeout: of never arrives, then a plain commit clears tmo.
    commit(-1, -1);
    host_write(3'd7, 16'h0000);
    commit(-1, -1);

    // Busy blocking: MSW write and second go mid-sequence are dropped.
    host_write(3'd1, 16'h2222);
    commit(-1, 3);
    check("busy_msw_kept", 32'(obs_cin[1]), 32'h2222);
    for (int i = 0; i < 12; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        check($sformatf("no_second_seq_cwr[%0d]", d), 32'(cwr[d]), 32'd0);
        check($sformatf("no_second_seq_busy[%0d]", d), 32'(busy[d]), 32'd0);
      end
    end

    // Reset mid-operation: rst sampled on the PH2 state cycle.
    host_write(3'd2, 16'h5555);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int d = 0; d < 2; d++) check($sformatf("pre_rst_cwr[%0d]", d), 32'(cwr[d]), 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst_cwr[%0d]", d), 32'(cwr[d]), 32'd0);
      check($sformatf("midrst_cin[%0d]", d), 32'(cin[d]), 32'd0);
      check($sformatf("midrst_busy[%0d]", d), 32'(busy[d]), 32'd0);
      check($sformatf("midrst_done[%0d]", d), 32'(done[d]), 32'd0);
      check($sformatf("midrst_herr[%0d]", d), 32'(herr[d]), 32'd0);
      check($sformatf("midrst_tmo[%0d]", d), 32'(tmo[d]), 32'd0);
    end
    model_reset();
    commit(-1, -1);

    // Randomised writes and commits against the model, back-to-back.
    for (int it = 0; it < 40; it++) begin
      int nw;
      int ofe;
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++)
        host_write(3'($urandom_range(0, 7)), 16'($urandom));
      ofe = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70));
      commit(ofe, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/resample_cfgseq.md
# resample_cfgseq

Configuration sequencer for the arbitrary-rate resampler. The host loads shadow registers (32-bit output rate word, four output-phase words, mode) at its own pace and issues one commit. The block then replays them onto the resampler's `cin`/`cwr` configuration port in a fixed, gap-free order, optionally aligned to the resampler's final-output flag, so that rate, phase and mode change atomically between output frames.

## Interface

Parameters:
- `TMO`, default 16'hFFFF: maximum cycles to wait for `of` in synchronous mode before forcing the update.

Ports:
- `clk`  in  1  master clock
- `rst`  in  1  master reset; synchronous, active-high
- `hd`  in  16  host write data
- `ha`  in  3  host register address:
  - 0: rate LSW (bits [15:4] used)
  - 1: rate MSW
  - 2–5: phase 0–3
  - 6: mode (bit0 VFO, bits[3:2] INT)
  - 7: control (bit0 SYNC)
- `hwe`  in  1  host write strobe
- `go`  in  1  commit request, single-cycle
- `of`  in  1  final-output flag from resampler
- `cin`  out  16  resampler configuration data
- `cwr`  out  4  resampler configuration write strobes, one-hot or zero
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse at end of sequence
- `herr`  out  1  sticky: host write or `go` dropped while busy
- `tmo`  out  1  sticky: SYNC wait timed out

## Operation

- **Shadow reset values:**
  - LSW = 16'h0000, MSW = 16'h1000 (rate = 1.0)
  - phases = 0, mode = 0, SYNC = 0
- **Shadow writes:**
  - `hwe` in IDLE writes `hd` to `ha`.
  - `hwe` while `busy` is dropped and sets `herr`.
- **Commit:**
  - `go` in IDLE starts the sequence and clears `tmo`.
  - `go` while busy is ignored and sets `herr`.
  - `herr` clears only on `rst`.
- **States:** IDLE → WAIT → LSW → MSW → PH3 → PH2 → PH1 → PH0 → MODE → DONE → IDLE.
- **WAIT:**
  - SYNC=0: exit after 1 cycle.
  - SYNC=1: exit on the cycle after `of`=1.
  - A 16-bit counter loaded with `TMO` decrements each cycle. At zero, the FSM exits and sets `tmo`.
- **Write states** each drive exactly one cycle:
  - LSW: `cwr`=0001, `cin`=LSW
  - MSW: `cwr`=0010, `cin`=MSW
  - PH3..PH0: `cwr`=0100, `cin`=phase k
  - MODE: `cwr`=1000, `cin`={12'h000, mode[3:0]}
- **Why LSW and MSW must be adjacent:** the resampler clears its LSW holding register on any MSW write. LSW and MSW are therefore issued on consecutive cycles and never separated.
- **Why phases go in 3→0 order:** the phase memory is a shift register whose tap 0 is the most recent write. Writing phase 3 first leaves phase k at tap k, which is the phase used for output sample k.
- **Outside write states:** `cwr`=0000 and `cin`=0. Both are registered outputs.
- **Shadow capture:** shadows are sampled when each word is emitted. Because host writes are blocked while busy, the emitted set equals the set present at `go`.
- **Reset mid-sequence:** FSM returns to IDLE and `cwr`=0 the next cycle. All shadows revert to their reset values, and `busy`, `done`, `herr` and `tmo` clear. The resampler is reset by the same `rst` and also returns to its defaults.

## Timing

- **Reset values:** `cin`=0, `cwr`=0, `busy`=0, `done`=0, `herr`=0, `tmo`=0.
- **Sequence timing with SYNC=0** (`go` sampled at edge 0):
  - `busy`=1 after edge 0.
  - LSW write visible after edge 2, MSW after edge 3.
  - Phases visible after edges 4–7, mode after edge 8.
  - `done`=1 after edge 9; `busy`=0 after edge 9.
- **SYNC=1:** if `of` is sampled at edge n, the LSW write is visible after edge n+1, and the rest follows as above.
- **Timeout:** forced exit after at most `TMO`+1 WAIT cycles.
- **Back-to-back commits:** a new `go` is accepted the cycle `done` is high (FSM already IDLE).
- **`of` outside WAIT** is ignored.

## Test plan

- **Reset defaults:** reset, then `go` with SYNC=0 → `cin` sequence 0000, 1000, 0000×4, 0000 with `cwr` 1,2,4,4,4,4,8 on consecutive cycles; `done` pulses after edge 9.
- **Full load:** write LSW=ABC0, MSW=1234, phases 0=0011, 1=0022, 2=0033, 3=0044, mode=000D; `go` → `cin` order ABC0, 1234, 0044, 0033, 0022, 0011, 000D. The resampler model reads phase k at tap k and has VFO=1, INT=3.
- **Sync alignment:** SYNC=1, `go`, `of` pulsed 37 cycles later → no `cwr` activity before; LSW write appears exactly 1 cycle after `of`.
- **Timeout:** TMO=8, SYNC=1, `of` held 0 → sequence starts after 9 WAIT cycles and `tmo`=1; a second `go` clears `tmo`.
- **Busy blocking:** `hwe` to MSW=FFFF and a second `go` mid-sequence → emitted MSW unchanged, only one sequence runs, `herr`=1.
- **Reset mid-operation:** `rst` on the PH2 cycle → `cwr`=0 the next cycle, `busy`=0, and a subsequent `go` emits reset defaults.
